// File: rtl/snn_pkg.sv
// Shared definitions for the SNN classification control path:
// scheduler states, AER reset-event count and the no-winner result code.
package snn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        SETTLE,
        REPORT
    } state_t;

    // The sorter emits two AER reset events before the first pixel event of a run.
    localparam int AER_RESET_EVENTS = 2;

    function automatic int unsigned noWinnerCode(input int unsigned outBits);
        return (32'd1 << outBits) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at LIMIT instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority over increment.
    always_ff @(posedge CLK) begin
        if (RST || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != WIDTH'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/inference_scheduler.sv
// Sequences one classification run: arms the sorter, takes the first valid
// output spike as the winner (or times out), drains the AER input path, then reports.
module inference_scheduler
    import snn_pkg::*;
#(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int N_OUT           = 10,
    parameter int OUT_BITS        = 4,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int TIMEOUT_BITS    = $clog2(TIMEOUT_CYCLES + 1),
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    output logic                     BUSY,
    output logic                     NEW_IMAGE,
    input  logic                     FOUND_NEXT_INDEX,
    input  logic                     IMAGE_ENCODED,
    input  logic                     AERIN_CTRL_BUSY,
    output logic                     INFERENCE_DONE,
    input  logic                     OUT_SPIKE_VALID,
    input  logic [OUT_BITS-1:0]      OUT_SPIKE_ADDR,
    output logic [OUT_BITS-1:0]      RESULT,
    output logic                     RESULT_VALID,
    output logic                     TIMED_OUT,
    output logic                     ENCODE_COMPLETE,
    output logic [IMAGE_SIZE_BITS:0] SPIKES_SENT
);

    localparam int EVENT_LIMIT = AER_RESET_EVENTS + IMAGE_SIZE;
    localparam int EVENT_BITS  = $clog2(EVENT_LIMIT + 1);
    localparam int SETTLE_BITS = $clog2(SETTLE_CYCLES + 1);
    localparam logic [OUT_BITS-1:0] NO_WINNER = OUT_BITS'(noWinnerCode(OUT_BITS));

    state_t r_state;

    logic                    w_arm;
    logic                    w_inRun;
    logic                    w_validSpike;
    logic                    w_expire;
    logic                    w_settleDone;
    logic                    w_pixelEvent;
    logic                    w_settleClear;
    logic [TIMEOUT_BITS-1:0] w_watchdog;
    logic [EVENT_BITS-1:0]   w_eventCount;
    logic [SETTLE_BITS-1:0]  w_settleCount;

    // Counters are cleared on the IDLE->ARM transition so ARM already shows a clean run.
    assign w_arm         = (r_state == IDLE) && START;
    assign w_inRun       = (r_state == RUN);
    assign w_validSpike  = OUT_SPIKE_VALID && (OUT_SPIKE_ADDR < OUT_BITS'(N_OUT));
    assign w_expire      = w_inRun && (w_watchdog == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));
    assign w_pixelEvent  = w_inRun && FOUND_NEXT_INDEX
                           && (w_eventCount >= EVENT_BITS'(AER_RESET_EVENTS));
    assign w_settleClear = (r_state != SETTLE) || AERIN_CTRL_BUSY;
    assign w_settleDone  = (r_state == SETTLE) && !AERIN_CTRL_BUSY
                           && (w_settleCount == SETTLE_BITS'(SETTLE_CYCLES - 1));

    sat_counter #(.WIDTH(TIMEOUT_BITS), .LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .CLK(CLK), .RST(RST), .i_clear(w_arm), .i_inc(w_inRun), .o_count(w_watchdog)
    );

    sat_counter #(.WIDTH(EVENT_BITS), .LIMIT(EVENT_LIMIT)) u_eventCount (
        .CLK(CLK), .RST(RST), .i_clear(w_arm), .i_inc(w_inRun && FOUND_NEXT_INDEX),
        .o_count(w_eventCount)
    );

    sat_counter #(.WIDTH(IMAGE_SIZE_BITS + 1), .LIMIT(IMAGE_SIZE)) u_spikesSent (
        .CLK(CLK), .RST(RST), .i_clear(w_arm), .i_inc(w_pixelEvent), .o_count(SPIKES_SENT)
    );

    sat_counter #(.WIDTH(SETTLE_BITS), .LIMIT(SETTLE_CYCLES)) u_settle (
        .CLK(CLK), .RST(RST), .i_clear(w_settleClear), .i_inc(1'b1), .o_count(w_settleCount)
    );

    // A valid spike is checked before watchdog expiry, so a spike on the last cycle wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= IDLE;
            BUSY            <= 1'b0;
            NEW_IMAGE       <= 1'b0;
            INFERENCE_DONE  <= 1'b0;
            RESULT          <= NO_WINNER;
            RESULT_VALID    <= 1'b0;
            TIMED_OUT       <= 1'b0;
            ENCODE_COMPLETE <= 1'b0;
        end else begin
            NEW_IMAGE    <= 1'b0;
            RESULT_VALID <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_state         <= ARM;
                        BUSY            <= 1'b1;
                        NEW_IMAGE       <= 1'b1;
                        RESULT          <= NO_WINNER;
                        TIMED_OUT       <= 1'b0;
                        ENCODE_COMPLETE <= 1'b0;
                    end
                end
                ARM: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (IMAGE_ENCODED) begin
                        ENCODE_COMPLETE <= 1'b1;
                    end
                    if (w_validSpike) begin
                        r_state        <= SETTLE;
                        RESULT         <= OUT_SPIKE_ADDR;
                        INFERENCE_DONE <= 1'b1;
                    end else if (w_expire) begin
                        r_state        <= SETTLE;
                        TIMED_OUT      <= 1'b1;
                        INFERENCE_DONE <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_settleDone) begin
                        r_state      <= REPORT;
                        RESULT_VALID <= 1'b1;
                    end
                end
                REPORT: begin
                    r_state        <= IDLE;
                    BUSY           <= 1'b0;
                    INFERENCE_DONE <= 1'b0;
                end
                default: begin
                    r_state        <= IDLE;
                    BUSY           <= 1'b0;
                    INFERENCE_DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
// Scoreboard bench for inference_scheduler: per-run input timelines are planned up front,
// a reference model predicts the report, and a monitor checks each RESULT_VALID pulse.
module tb_inference_scheduler;

    localparam int IMG  = 16;
    localparam int NOUT = 10;
    localparam int OB   = 4;
    localparam int TO   = 100;
    localparam int SC   = 8;
    localparam int SB   = $clog2(IMG) + 1;
    localparam int L    = TO + 80;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          FOUND_NEXT_INDEX;
    logic          IMAGE_ENCODED;
    logic          AERIN_CTRL_BUSY;
    logic          OUT_SPIKE_VALID;
    logic [OB-1:0] OUT_SPIKE_ADDR;
    logic          BUSY;
    logic          NEW_IMAGE;
    logic          INFERENCE_DONE;
    logic [OB-1:0] RESULT;
    logic          RESULT_VALID;
    logic          TIMED_OUT;
    logic          ENCODE_COMPLETE;
    logic [SB-1:0] SPIKES_SENT;

    inference_scheduler #(
        .IMAGE_SIZE(IMG), .N_OUT(NOUT), .OUT_BITS(OB),
        .TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .NEW_IMAGE(NEW_IMAGE),
        .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX), .IMAGE_ENCODED(IMAGE_ENCODED),
        .AERIN_CTRL_BUSY(AERIN_CTRL_BUSY), .INFERENCE_DONE(INFERENCE_DONE),
        .OUT_SPIKE_VALID(OUT_SPIKE_VALID), .OUT_SPIKE_ADDR(OUT_SPIKE_ADDR),
        .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .TIMED_OUT(TIMED_OUT),
        .ENCODE_COMPLETE(ENCODE_COMPLETE), .SPIKES_SENT(SPIKES_SENT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int res;
        int timedOut;
        int enc;
        int spikes;
        int cycle;
    } exp_t;

    exp_t sbq[$];

    // Per-run input timeline, indexed by cycle since RUN entry.
    bit         fniA  [L];
    bit         encA  [L];
    bit         busyA [L];
    bit         svA   [L];
    logic [3:0] saA   [L];

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clearPlan();
        for (int t = 0; t < L; t++) begin
            fniA[t] = 0; encA[t] = 0; busyA[t] = 0; svA[t] = 0; saA[t] = 4'd0;
        end
    endtask

    task automatic randomPlan();
        for (int t = 0; t < L; t++) begin
            fniA[t]  = ($urandom % 2) == 0;
            encA[t]  = ($urandom % 40) == 0;
            svA[t]   = ($urandom % 25) == 0;
            saA[t]   = 4'($urandom % 16);
            busyA[t] = ($urandom % 3) == 0;
        end
        for (int t = L - 12; t < L; t++) busyA[t] = 0;
    endtask

    // Reference model: first in-range spike within the watchdog window wins,
    // pixel count is strobes minus the two reset events (clamped), report
    // follows the SC-th consecutive idle cycle after the decision.
    task automatic model(output int endIdx, output int repIdx, output exp_t e);
        int n;
        int run;
        n = 0;
        endIdx = TO - 1;
        e.res = 15;
        e.timedOut = 1;
        e.enc = 0;
        for (int t = 0; t < TO; t++) begin
            if (svA[t] && (int'(saA[t]) < NOUT)) begin
                endIdx = t;
                e.res = int'(saA[t]);
                e.timedOut = 0;
                break;
            end
        end
        for (int t = 0; t <= endIdx; t++) begin
            n += int'(fniA[t]);
            if (encA[t]) e.enc = 1;
        end
        e.spikes = (n > 2) ? n - 2 : 0;
        if (e.spikes > IMG) e.spikes = IMG;
        run = 0;
        repIdx = L;
        for (int t = endIdx + 1; t < L; t++) begin
            run = busyA[t] ? 0 : run + 1;
            if (run == SC) begin
                repIdx = t + 1;
                break;
            end
        end
        e.cycle = 0;
    endtask

    task automatic applyStimulus(input int t);
        if (t < L) begin
            FOUND_NEXT_INDEX = fniA[t];
            IMAGE_ENCODED    = encA[t];
            AERIN_CTRL_BUSY  = busyA[t];
            OUT_SPIKE_VALID  = svA[t];
            OUT_SPIKE_ADDR   = saA[t];
        end else begin
            FOUND_NEXT_INDEX = 0; IMAGE_ENCODED = 0; AERIN_CTRL_BUSY = 0;
            OUT_SPIKE_VALID = 0; OUT_SPIKE_ADDR = '0;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " BUSY"}, int'(BUSY), 0);
        checkOutput({tag, " NEW_IMAGE"}, int'(NEW_IMAGE), 0);
        checkOutput({tag, " INFERENCE_DONE"}, int'(INFERENCE_DONE), 0);
        checkOutput({tag, " RESULT_VALID"}, int'(RESULT_VALID), 0);
        checkOutput({tag, " TIMED_OUT"}, int'(TIMED_OUT), 0);
        checkOutput({tag, " ENCODE_COMPLETE"}, int'(ENCODE_COMPLETE), 0);
        checkOutput({tag, " RESULT"}, int'(RESULT), 15);
        checkOutput({tag, " SPIKES_SENT"}, int'(SPIKES_SENT), 0);
    endtask

    // One run: START in an IDLE cycle, ARM, then the planned RUN/SETTLE/REPORT timeline.
    // With doReset set, RST is pulsed at timeline index resetAt and nothing is scoreboarded.
    task automatic runOne(input bit doReset, input int resetAt);
        exp_t e;
        int   endIdx;
        int   repIdx;
        model(endIdx, repIdx, e);
        @(posedge CLK); #1;
        applyStimulus(L);
        START = 1;
        @(negedge CLK);
        checkOutput("idle BUSY", int'(BUSY), 0);
        checkOutput("idle INFERENCE_DONE", int'(INFERENCE_DONE), 0);
        @(posedge CLK); #1;
        START = 0;
        @(negedge CLK);
        checkOutput("arm NEW_IMAGE", int'(NEW_IMAGE), 1);
        checkOutput("arm BUSY", int'(BUSY), 1);
        @(posedge CLK); #1;
        e.cycle = cyc + repIdx;
        if (!doReset) sbq.push_back(e);
        for (int t = 0; t <= repIdx; t++) begin
            if (t > 0) begin
                @(posedge CLK); #1;
            end
            applyStimulus(t);
            if (doReset) begin
                RST = (t == resetAt);
                if (t == resetAt + 1) begin
                    applyStimulus(L);
                    @(negedge CLK);
                    checkResetValues("after mid-run reset");
                    break;
                end
                @(negedge CLK);
            end else begin
                @(negedge CLK);
                if (t == 0) checkOutput("run NEW_IMAGE", int'(NEW_IMAGE), 0);
                checkOutput("run BUSY", int'(BUSY), 1);
                checkOutput("INFERENCE_DONE", int'(INFERENCE_DONE),
                            int'((t > endIdx) && (t <= repIdx)));
                checkOutput("RESULT_VALID timing", int'(RESULT_VALID), int'(t == repIdx));
                if (t > endIdx) begin
                    checkOutput("settle RESULT", int'(RESULT), e.res);
                    checkOutput("settle SPIKES_SENT", int'(SPIKES_SENT), e.spikes);
                end
            end
        end
    endtask

    // Monitor: every RESULT_VALID pulse must match the oldest outstanding prediction.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RESULT_VALID) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected RESULT_VALID", 1, 0);
            end else begin
                e = sbq.pop_front();
                checkOutput("RESULT", int'(RESULT), e.res);
                checkOutput("TIMED_OUT", int'(TIMED_OUT), e.timedOut);
                checkOutput("ENCODE_COMPLETE", int'(ENCODE_COMPLETE), e.enc);
                checkOutput("SPIKES_SENT", int'(SPIKES_SENT), e.spikes);
                checkOutput("report cycle", cyc, e.cycle);
                checkOutput("report INFERENCE_DONE", int'(INFERENCE_DONE), 1);
            end
        end
    end

    initial begin : watchdogTimer
        #500000;
        $display("[TB] FAIL global timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : mainStimulus
        RST = 1; START = 0;
        applyStimulus(L);
        repeat (3) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        checkResetValues("reset");

        // Basic win: 2 reset strobes + 5 pixels, spike on neuron 3.
        clearPlan();
        for (int t = 0; t < 7; t++) fniA[t] = 1;
        svA[10] = 1; saA[10] = 4'd3;
        runOne(0, 0);

        // Timeout with IMAGE_ENCODED mid-run.
        clearPlan();
        for (int t = 0; t < 5; t++) fniA[t] = 1;
        encA[40] = 1;
        runOne(0, 0);

        // Out-of-range spike ignored; valid spike on the expiry cycle wins.
        clearPlan();
        svA[20] = 1; saA[20] = 4'd12;
        saA[50] = 4'd2;
        svA[TO-1] = 1; saA[TO-1] = 4'd7;
        runOne(0, 0);

        // Drain: AER busy every 5th cycle for 20 cycles after the win.
        clearPlan();
        svA[5] = 1; saA[5] = 4'd1;
        for (int j = 0; j < 20; j++) busyA[6 + j] = (j % 5) == 4;
        runOne(0, 0);

        // Late strobes and spikes during SETTLE must not disturb the result.
        clearPlan();
        for (int t = 0; t < L; t++) fniA[t] = 1;
        svA[8] = 1; saA[8] = 4'd9;
        for (int t = 9; t < L; t++) begin
            svA[t] = ($urandom % 2) == 0;
            saA[t] = 4'($urandom % 10);
        end
        for (int t = 9; t < 9 + 6; t++) busyA[t] = 1;
        runOne(0, 0);

        // Saturation of the pixel count, with encode on the winning cycle.
        clearPlan();
        for (int t = 0; t < 40; t++) fniA[t] = 1;
        svA[45] = 1; saA[45] = 4'd0; encA[45] = 1;
        runOne(0, 0);

        // Reset mid-RUN, then a fresh run whose counters restart from zero.
        clearPlan();
        for (int t = 0; t < 20; t++) fniA[t] = 1;
        encA[3] = 1;
        runOne(1, 12);
        clearPlan();
        for (int t = 0; t < 4; t++) fniA[t] = 1;
        svA[6] = 1; saA[6] = 4'd5;
        runOne(0, 0);

        // Randomised runs, back-to-back or with a short idle gap.
        for (int r = 0; r < 8; r++) begin
            randomPlan();
            if (($urandom % 2) == 0) begin
                repeat (1 + ($urandom % 3)) @(posedge CLK);
            end
            runOne(0, 0);
        end

        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checkOutput("scoreboard drained", sbq.size(), 0);
        checkOutput("final BUSY", int'(BUSY), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
